fetch_pc_unit: RTL

Instruction-fetch front end of the RV32I pipeline: owns the program counter, issues one instruction-memory request at a time, and presents each fetched instruction to the IF/ID register. It consumes the execute-stage redirect decision (branch taken or jump) produced by the control unit. On a redirect it moves to the new target, kills any wrong-path fetch, and drives the decode and execute flushes.

---
 rtl/fetch_pc_unit_if.sv | 25 ++
 rtl/fetch_pc_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and imem.
// One request outstanding at a time; rdata qualified by rvalid.
interface fetch_pc_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// RV32I fetch front end: owns the PC, issues single-outstanding imem requests,
// presents fetched instructions to IF/ID and applies execute-stage redirects.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_f,
    input  logic               pcsrc_e,
    input  logic [31:0]        pc_target_e,
    fetch_pc_unit_if.master    imem,
    output logic [31:0]        instr_f,
    output logic [31:0]        pc_f,
    output logic [31:0]        pc_plus4_f,
    output logic               instr_valid_f,
    output logic               flush_d,
    output logic               flush_e,
    output logic               misalign_err,
    output logic [CNT_W-1:0]   redirect_cnt
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        drop;
    logic        redirect;
    logic [31:0] target_aligned;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Redirects are meaningless until the first fetch has been set up.
    assign redirect       = pcsrc_e && (state != S_BOOT);
    assign target_aligned = {pc_target_e[31:2], 2'b00};

    assign imem.imem_req  = (state == S_REQ) && !pcsrc_e;
    assign imem.imem_addr = pc;
    assign instr_valid_f  = (state == S_HOLD);
    assign instr_f        = instr_q;
    assign pc_f           = pc_q;
    assign pc_plus4_f     = pc_q + 32'd4;
    assign flush_d        = redirect;
    assign flush_e        = redirect;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_BOOT;
            pc           <= RESET_PC;
            instr_q      <= '0;
            pc_q         <= RESET_PC;
            drop         <= 1'b0;
            misalign_err <= 1'b0;
            redirect_cnt <= '0;
        end else begin
            if (redirect) begin
                redirect_cnt <= sat_inc(redirect_cnt);
                if (pc_target_e[1:0] != 2'b00) misalign_err <= 1'b1;
            end

            case (state)
                S_BOOT: state <= S_REQ;
                S_REQ: begin
                    if (redirect) begin
                        pc <= target_aligned;
                    end else if (imem.imem_gnt) begin
                        state <= S_WAIT;
                        drop  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // A redirect while waiting marks the in-flight response as wrong-path.
                    if (imem.imem_rvalid) begin
                        if (!drop && !redirect) begin
                            instr_q <= imem.imem_rdata;
                            pc_q    <= pc;
                            state   <= S_HOLD;
                        end else begin
                            if (redirect) pc <= target_aligned;
                            state <= S_REQ;
                        end
                    end else if (redirect) begin
                        pc   <= target_aligned;
                        drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc    <= target_aligned;
                        state <= S_REQ;
                    end else if (!stall_f) begin
                        pc    <= pc_q + 32'd4;
                        state <= S_REQ;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

endmodule
